// File: rtl/mips_pkg.sv
// Shared encodings for the memory-access stage.
// FSM state type, word-alignment mask and alignment helper.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } mem_state_t;

  localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

  function automatic logic is_aligned(input logic [31:0] a);
    return (a & ALIGN_MASK) == 32'h0;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait counter for outstanding data-memory requests.
// Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout_ctr #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires on the no-ack cycle that brings the count to LIMIT.
  assign expired = inc && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: load/store handshake with data memory.
// Optional request timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        misalign_err,
  output logic        timeout_err
);

  mem_state_t  state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [31:0] data_q;
  logic        mis_q;
  logic        accept;
  logic        is_mem;
  logic        aligned;
  logic        in_req;
  logic        expired;

  assign accept  = in_valid && (state_q == ST_IDLE);
  assign is_mem  = mem_read || mem_write;
  assign aligned = is_aligned(alu_result);
  assign in_req  = (state_q == ST_REQ);

`ifdef MEM_TIMEOUT_EN
  logic tmo_q;

  mem_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .inc    (in_req && !dmem_ack),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= 1'b0;
    end else if (accept) begin
      tmo_q <= 1'b0;
    end else if (in_req && !dmem_ack && expired) begin
      tmo_q <= 1'b1;
    end
  end

  assign timeout_err = tmo_q;
`else
  logic unused_tmo;
  assign unused_tmo  = ^TIMEOUT_CYCLES;
  assign expired     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (is_mem && aligned) ? ST_REQ : ST_RESP;
        end
      end
      ST_REQ: begin
        if (dmem_ack || expired) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Op fields latch on accept and stay put for the whole request.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= alu_result & ~ALIGN_MASK;
        wdata_q <= store_data;
        we_q    <= mem_write;
        mis_q   <= is_mem && !aligned;
        data_q  <= is_mem ? 32'h0 : alu_result;
      end
      if (in_req && dmem_ack) begin
        data_q <= we_q ? addr_q : dmem_rdata;
      end else if (in_req && expired) begin
        data_q <= 32'h0;
      end
    end
  end

  assign in_ready     = (state_q == ST_IDLE);
  assign out_valid    = (state_q == ST_RESP);
  assign dmem_req     = in_req;
  assign dmem_we      = in_req && we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign out_data     = data_q;
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access.
// Timeout scenario runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        misalign_err;
  logic        timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_result  (alu_result),
    .store_data  (store_data),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_ack    (dmem_ack),
    .dmem_rdata  (dmem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .misalign_err(misalign_err),
    .timeout_err (timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       input logic rd, input logic wr);
    in_valid   = 1'b1;
    alu_result = a;
    store_data = d;
    mem_read   = rd;
    mem_write  = wr;
    tick();
    in_valid   = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    alu_result = '0;
    store_data = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    out_ready  = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_dmem_addr", dmem_addr, 32'h0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);

    // Non-memory op passes alu_result through
    issue(32'h0000_0010, 32'h0, 1'b0, 1'b0);
    chk("alu_out_valid", 32'(out_valid), 32'd1);
    chk("alu_out_data", out_data, 32'h10);
    chk("alu_no_req", 32'(dmem_req), 32'd0);
    chk("alu_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("alu_done", 32'(out_valid), 32'd0);
    chk("alu_idle", 32'(in_ready), 32'd1);

    // Load with three wait cycles then ack
    issue(32'h0000_0100, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("ld_req", 32'(dmem_req), 32'd1);
      chk("ld_addr", dmem_addr, 32'h100);
      chk("ld_we", 32'(dmem_we), 32'd0);
      chk("ld_no_valid", 32'(out_valid), 32'd0);
      tick();
    end
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    chk("ld_req4", 32'(dmem_req), 32'd1);
    chk("ld_addr4", dmem_addr, 32'h100);
    tick();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    chk("ld_valid", 32'(out_valid), 32'd1);
    chk("ld_data", out_data, 32'hDEAD_BEEF);
    chk("ld_req_off", 32'(dmem_req), 32'd0);
    tick();
    chk("ld_idle", 32'(in_ready), 32'd1);

    // Misaligned store: no request, error flagged
    issue(32'h0000_0003, 32'h1234, 1'b0, 1'b1);
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_valid", 32'(out_valid), 32'd1);
    chk("mis_err", 32'(misalign_err), 32'd1);
    chk("mis_data", out_data, 32'h0);
    tick();
    chk("mis_idle", 32'(in_ready), 32'd1);

    // Store with back-pressure from writeback
    out_ready = 1'b0;
    issue(32'h0000_0020, 32'h55, 1'b0, 1'b1);
    chk("st_req", 32'(dmem_req), 32'd1);
    chk("st_we", 32'(dmem_we), 32'd1);
    chk("st_addr", dmem_addr, 32'h20);
    chk("st_wdata", dmem_wdata, 32'h55);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("st_hold_valid", 32'(out_valid), 32'd1);
      chk("st_hold_data", out_data, 32'h20);
      chk("st_hold_ready", 32'(in_ready), 32'd0);
      chk("st_hold_mis", 32'(misalign_err), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("st_done", 32'(out_valid), 32'd0);

    // Both read and write set: treated as a store
    issue(32'h0000_0044, 32'hA5A5, 1'b1, 1'b1);
    chk("rw_we", 32'(dmem_we), 32'd1);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    tick();
    dmem_ack   = 1'b0;
    chk("rw_data", out_data, 32'h44);
    tick();

    // Stray ack while idle is ignored
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("stray_valid", 32'(out_valid), 32'd0);
    chk("stray_ready", 32'(in_ready), 32'd1);

    // Reset during REQ abandons the load
    issue(32'h0000_0040, 32'h0, 1'b1, 1'b0);
    chk("rq_req", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rq_req_off", 32'(dmem_req), 32'd0);
    chk("rq_addr", dmem_addr, 32'h0);
    dmem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rq_no_valid", 32'(out_valid), 32'd0);
    end
    dmem_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
    // No ack: four REQ cycles then timeout
    issue(32'h0000_0080, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("to_req", 32'(dmem_req), 32'd1);
      tick();
    end
    chk("to_valid", 32'(out_valid), 32'd1);
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_data", out_data, 32'h0);
    chk("to_req_off", 32'(dmem_req), 32'd0);
    tick();
    // Ack on the expiry cycle wins
    issue(32'h0000_0084, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0BAD_F00D;
    tick();
    dmem_ack   = 1'b0;
    chk("to_race_err", 32'(timeout_err), 32'd0);
    chk("to_race_data", out_data, 32'h0BAD_F00D);
    tick();
`else
    // No timeout: request waits indefinitely
    issue(32'h0000_0080, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("wait_req", 32'(dmem_req), 32'd1);
    chk("wait_tmo", 32'(timeout_err), 32'd0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0BAD_F00D;
    tick();
    dmem_ack   = 1'b0;
    chk("wait_data", out_data, 32'h0BAD_F00D);
    tick();
`endif

    // Back-to-back non-memory ops every two cycles
    in_valid   = 1'b1;
    alu_result = 32'h111;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    tick();
    alu_result = 32'h222;
    chk("tp_first", out_data, 32'h111);
    tick();
    chk("tp_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("tp_second", out_data, 32'h222);
    chk("tp_valid", 32'(out_valid), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, max dmem_ack wait cycles (used only with MEM_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  execute result presented.
REQ-005 in_ready  output  1  stage can accept a new op.
REQ-006 alu_result  input  32  execute ALU result; byte address for memory ops.
REQ-007 store_data  input  32  register operand 2, store data.
REQ-008 mem_read  input  1  op is a load.
REQ-009 mem_write  input  1  op is a store.
REQ-010 dmem_req  output  1  data memory request.
REQ-011 dmem_we  output  1  request is a write.
REQ-012 dmem_addr  output  32  word-aligned memory address.
REQ-013 dmem_wdata  output  32  write data.
REQ-014 dmem_ack  input  1  memory completed request this cycle.
REQ-015 dmem_rdata  input  32  read data, valid with dmem_ack.
REQ-016 out_valid  output  1  result for writeback valid.
REQ-017 out_ready  input  1  writeback accepts result.
REQ-018 out_data  output  32  load data or passed-through alu_result.
REQ-019 misalign_err  output  1  result carries misaligned-access error.
REQ-020 timeout_err  output  1  result carries timeout error (tied 0 without MEM_TIMEOUT_EN).

Function
REQ-021 FSM states IDLE, REQ, RESP; in_ready SHALL be 1 only in IDLE.
REQ-022 Accept = in_valid & in_ready; op fields SHALL be registered on accept.
REQ-023 Non-memory op (mem_read=mem_write=0): IDLE->RESP, out_data=alu_result, out_valid 1 cycle after accept.
REQ-024 Memory op with alu_result[1:0]==0: IDLE->REQ; dmem_req, dmem_addr, dmem_we, dmem_wdata SHALL stay stable until dmem_ack.
REQ-025 mem_read and mem_write both 1 SHALL be treated as a store.
REQ-026 In REQ with dmem_ack=1: ->RESP next edge; load captures dmem_rdata into out_data; store sets out_data=alu_result.
REQ-027 dmem_ack outside REQ SHALL be ignored.
REQ-028 Memory op with alu_result[1:0]!=0: no dmem_req; IDLE->RESP, misalign_err=1, out_data=0.
REQ-029 In RESP out_valid=1, out_data and error flags held until out_ready; on out_ready ->IDLE.
REQ-030 Minimum throughput: one op per 2 cycles (non-memory), one per 3 cycles (memory, zero-wait ack).

Reset
REQ-031 rst SHALL force IDLE and clear out_valid, dmem_req, dmem_we, misalign_err, timeout_err, out_data, dmem_addr, dmem_wdata to 0 at next edge.
REQ-032 rst during REQ or RESP SHALL abandon the op; no result SHALL be produced later.

Configuration
REQ-033 Macro MEM_TIMEOUT_EN defined: counter clears on REQ entry, increments each REQ cycle without ack; reaching TIMEOUT_CYCLES SHALL force RESP with timeout_err=1, out_data=0, dmem_req deasserted.
REQ-034 Ack in the same cycle as counter reaching TIMEOUT_CYCLES SHALL win (normal completion).
REQ-035 Macro undefined: no counter logic; REQ waits indefinitely; timeout_err tied 0.

Structure
REQ-036 FSM state encoding and ALIGN_MASK constant SHALL live in shared package mips_pkg.
REQ-037 Timeout counter SHALL be sub-module mem_timeout_ctr, instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-038 Non-memory op alu_result=0x0000_0010, out_ready=1 -> out_valid one cycle after accept, out_data=0x10.
REQ-039 Load addr 0x100, ack after 3 wait cycles with rdata 0xDEAD_BEEF -> dmem_req stable 4 cycles, out_data=0xDEADBEEF.
REQ-040 Store addr 0x0000_0003 -> no dmem_req, misalign_err=1, out_data=0.
REQ-041 Store addr 0x20 data 0x55, out_ready held 0 for 5 cycles -> out_valid/out_data=0x20 held stable, in_ready=0 throughout.
REQ-042 rst asserted in REQ -> dmem_req=0 next cycle, no out_valid afterwards.
REQ-043 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> RESP after 4 REQ cycles, timeout_err=1, out_data=0.
